parity_push_tx: RTL and testbench
=================================

Name: parity_push_tx

Overview:
- Producer-side front end for the parity-protected FIFO (`top`). It drives the FIFO's push interface.
- Takes raw DATA_WIDTH-bit words from an upstream valid/ready source and appends a parity bit in position DATA_WIDTH.
- Presents the DATA_WIDTH+1-bit word on push_data_o / push_valid_o, qualified by push_grant_i.
- A 2-entry skid buffer keeps all handshake outputs registered while sustaining 1 word/cycle. A wrapping counter reports completed pushes.

Parameters:
- DATA_WIDTH, 32, payload width; output word is DATA_WIDTH+1 bits.
- EVEN_ODD, 0, 0 = even parity (total ones incl. parity bit even), 1 = odd parity.
- PARITY_BIT, 1, 1 = generate parity into bit DATA_WIDTH; 0 = bit DATA_WIDTH driven 0.
- CNT_WIDTH, 32, width of tx_count_o.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data_i  input  DATA_WIDTH  raw payload from upstream.
- in_valid_i  input  1  upstream has a word.
- in_ready_o  output  1  block can accept a word this cycle.
- push_data_o  output  DATA_WIDTH+1  {parity, payload} to FIFO push_data_i.
- push_valid_o  output  1  to FIFO push_valid_i.
- push_grant_i  input  1  from FIFO push_grant_o; FIFO accepts this cycle.
- inject_i  input  1  arm one-shot parity corruption (see Optional Feature).
- inject_pending_o  output  1  corruption armed, not yet applied.
- tx_count_o  output  CNT_WIDTH  number of completed push transfers, wraps.

Behaviour:
- Reset: asynchronous on rst_n low; takes effect immediately, mid-transfer included. All stored words are discarded, state EMPTY.
  - Output values in reset: in_ready_o=0, push_valid_o=0, push_data_o=0, tx_count_o=0, inject_pending_o=0.
  - in_ready_o goes 1 on the first rising edge after rst_n deasserts.
- Accept: in_valid_i && in_ready_o at a rising edge.
- Transfer: push_valid_o && push_grant_i at a rising edge.
- Parity, computed at accept time:
  - p = ^in_data_i, XORed with EVEN_ODD.
  - Stored word = {PARITY_BIT ? p : 1'b0, in_data_i}.
- Storage: an output register (OUT) and a skid register (SKID), with states EMPTY, ONE, TWO.
  - EMPTY: in_ready_o=1, push_valid_o=0. On accept, go to ONE (word into OUT).
  - ONE: in_ready_o=1, push_valid_o=1.
    - Accept and transfer together: OUT replaced by the new word, stay ONE.
    - Accept only: new word into SKID, go TWO.
    - Transfer only: go EMPTY.
  - TWO: in_ready_o=0, push_valid_o=1.
    - Transfer: OUT <= SKID, go ONE.
    - No accept is possible in TWO.
- Latency: an accepted word appears on push_data_o the cycle after accept. With grant held high, throughput is 1 word/cycle.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- Stability: while push_valid_o=1 and push_grant_i=0, push_data_o holds its value and push_valid_o does not drop.
- in_ready_o and push_valid_o are register outputs; no combinational path from push_grant_i to in_ready_o.
- tx_count_o: increments by 1 on each transfer, wraps from 2^CNT_WIDTH-1 to 0.
- push_grant_i high while push_valid_o=0: ignored, counter unchanged.

Optional Feature:
- Macro: PARITY_PUSH_TX_INJECT_EN.
- Defined:
  - A high sample of inject_i at a rising edge sets inject_pending_o to 1.
  - The next accepted word has its parity bit inverted before storage, and inject_pending_o clears on that same edge.
  - If inject_i and an accept occur on the same edge, the word being accepted is corrupted and pending stays 0.
  - Further inject_i while pending is set has no additional effect.
- Not defined: inject_i is ignored, inject_pending_o is tied to 0, and parity is always correct. Port list is identical in both builds.

Test Plan:
- Reset then idle: rst_n=0 for 5 ns then released → in_ready_o=1 one edge later; push_valid_o=0 and tx_count_o=0 throughout.
- Even parity, grant held 1: input 0x00000003 then 0x00000007, EVEN_ODD=0 → push_data_o = 0x0_00000003 then 0x1_00000007 on consecutive cycles; tx_count_o=2.
- Odd parity: EVEN_ODD=1, input 0x00000000 → push_data_o=0x1_00000000.
- Backpressure: grant=0, push 0x3, 0x6, 0x9 with in_valid_i held → first two accepted, in_ready_o=0, push_data_o stable at 0x0_00000003. Then grant=1 for 3 cycles → output order 0x3, 0x6, 0x9 with no loss; tx_count_o=3.
- Async reset mid-stream: state TWO, rst_n pulsed low between edges → push_valid_o=0 immediately, tx_count_o=0, stored words not re-emitted.
- With PARITY_PUSH_TX_INJECT_EN: pulse inject_i, then push 0x00000003 → push_data_o=0x1_00000003; inject_pending_o back to 0; next word 0x6 carries correct parity (0x0_00000006). FIFO's parity checker discards the corrupted word.

Source files
------------

// File: rtl/parity_push_tx.sv
// parity_push_tx: producer-side front end for the parity-protected FIFO.
// Takes raw payload words from an upstream valid/ready source, appends a
// parity bit at position DATA_WIDTH and presents the result on the FIFO push
// interface through a two-entry skid buffer, so that every handshake output
// comes straight from a flop while still moving one word per cycle.
// A wrapping counter reports how many pushes the FIFO has accepted.
//
// Optional build macro: PARITY_PUSH_TX_INJECT_EN
//   When defined, inject_i arms a one-shot inversion of the parity bit of the
//   next accepted word (used to exercise the FIFO's parity checker).
//   When undefined, inject_i is ignored and inject_pending_o is tied low.
module parity_push_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int EVEN_ODD   = 0,
   parameter int PARITY_BIT = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH:0]   push_data_o,
   output logic                  push_valid_o,
   input  logic                  push_grant_i,
   input  logic                  inject_i,
   output logic                  inject_pending_o,
   output logic [CNT_WIDTH-1:0]  tx_count_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH:0]   out_q;
   logic [DATA_WIDTH:0]   skid_q;
   logic                  in_ready_q;
   logic                  push_valid_q;
   logic [CNT_WIDTH-1:0]  count_q;

   logic                  accept;
   logic                  transfer;
   logic                  parity_bit;
   logic                  corrupt;
   logic [DATA_WIDTH:0]   new_word;

   assign accept   = in_valid_i & in_ready_q;
   assign transfer = push_valid_q & push_grant_i;

   // The parity bit is fixed at accept time; the stored word never changes
   // afterwards, so the FIFO sees exactly what was computed here.
   assign parity_bit = (PARITY_BIT != 0) ? ((^in_data_i) ^ (EVEN_ODD != 0)) : 1'b0;
   assign new_word   = {parity_bit ^ corrupt, in_data_i};

`ifdef PARITY_PUSH_TX_INJECT_EN
   logic inject_pending_q;

   // An inject request applies to the word accepted on the same edge if there
   // is one; otherwise it stays armed until the next accept consumes it.
   assign corrupt = accept & (inject_pending_q | inject_i);

   // Arm on inject_i, disarm on the accept that carries the corruption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inject_pending_q <= 1'b0;
      end else if (accept) begin
         inject_pending_q <= 1'b0;
      end else if (inject_i) begin
         inject_pending_q <= 1'b1;
      end
   end

   assign inject_pending_o = inject_pending_q;
`else
   logic unused_inject;

   assign unused_inject    = inject_i;
   assign corrupt          = 1'b0;
   assign inject_pending_o = 1'b0;
`endif

   // Skid-buffer state machine: OUT always holds the head word, SKID the one
   // behind it. Ready and valid are registered from the next state so that
   // push_grant_i never reaches in_ready_o combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         out_q        <= '0;
         skid_q       <= '0;
         in_ready_q   <= 1'b0;
         push_valid_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  out_q        <= new_word;
                  push_valid_q <= 1'b1;
                  state_q      <= ONE;
               end
            end
            ONE: begin
               if (accept && transfer) begin
                  out_q <= new_word;
               end else if (accept) begin
                  skid_q     <= new_word;
                  in_ready_q <= 1'b0;
                  state_q    <= TWO;
               end else if (transfer) begin
                  push_valid_q <= 1'b0;
                  state_q      <= EMPTY;
               end
            end
            TWO: begin
               if (transfer) begin
                  out_q      <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ONE;
               end
            end
            default: begin
               in_ready_q   <= 1'b0;
               push_valid_q <= 1'b0;
               state_q      <= EMPTY;
            end
         endcase
      end
   end

   // Count completed pushes; natural wrap at 2^CNT_WIDTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (transfer) begin
         count_q <= count_q + CNT_WIDTH'(1);
      end
   end

   assign in_ready_o   = in_ready_q;
   assign push_valid_o = push_valid_q;
   assign push_data_o  = out_q;
   assign tx_count_o   = count_q;

endmodule

// File: tb/tb_parity_push_tx.sv
// tb_parity_push_tx: self-checking bench for parity_push_tx.
// A second instance built for odd parity shares all inputs with the main
// (even parity) instance. Expected behaviour comes from a queue-based model
// of the buffered words plus a $countones-based parity rule.
module tb_parity_push_tx;

   localparam int DW = 32;
   localparam int EVEN_ODD = 0;
`ifdef PARITY_PUSH_TX_INJECT_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] in_data_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW:0]   push_data_o;
   logic          push_valid_o;
   logic          push_grant_i;
   logic          inject_i;
   logic          inject_pending_o;
   logic [31:0]   tx_count_o;

   logic          unused_odd_ready;
   logic [DW:0]   odd_data;
   logic          odd_valid;
   logic          unused_odd_pending;
   logic [31:0]   unused_odd_count;

   int pass_count = 0;
   int check_count = 0;

   // behavioural model state
   logic [DW:0]   model_q[$];
   bit            model_armed;
   logic [31:0]   model_cnt;
   bit            model_pend;

   parity_push_tx #(.DATA_WIDTH(DW), .EVEN_ODD(EVEN_ODD), .PARITY_BIT(1), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .push_data_o(push_data_o), .push_valid_o(push_valid_o),
      .push_grant_i(push_grant_i), .inject_i(inject_i), .inject_pending_o(inject_pending_o),
      .tx_count_o(tx_count_o)
   );

   parity_push_tx #(.DATA_WIDTH(DW), .EVEN_ODD(1), .PARITY_BIT(1), .CNT_WIDTH(32)) dut_odd (
      .clk(clk), .rst_n(rst_n), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
      .in_ready_o(unused_odd_ready), .push_data_o(odd_data), .push_valid_o(odd_valid),
      .push_grant_i(push_grant_i), .inject_i(inject_i), .inject_pending_o(unused_odd_pending),
      .tx_count_o(unused_odd_count)
   );

   // negedge at 5 ns, posedges at 10, 20, ...
   initial clk = 1'b1;
   always #5 clk = ~clk;

   function automatic logic [DW:0] model_word(input logic [DW-1:0] d, input bit flip);
      int ones;
      bit p;
      ones = $countones(d);
      p = ((ones + EVEN_ODD) % 2) == 1;
      return {p ^ flip, d};
   endfunction

   task automatic model_reset();
      model_q.delete();
      model_armed = 1'b0;
      model_cnt = '0;
      model_pend = 1'b0;
   endtask

   // drive one cycle of inputs and advance the model across the rising edge
   task automatic step(input bit v, input logic [DW-1:0] d, input bit g, input bit inj);
      bit acc;
      bit xfer;
      bit flip;
      @(negedge clk);
      in_valid_i = v; in_data_i = d; push_grant_i = g; inject_i = inj;
      @(posedge clk);
      acc  = v && model_armed && (model_q.size() < 2);
      xfer = g && (model_q.size() > 0);
      flip = INJ && acc && (model_pend || inj);
      if (xfer) begin
         void'(model_q.pop_front());
         model_cnt = model_cnt + 1;
      end
      if (acc) model_q.push_back(model_word(d, flip));
      if (INJ) begin
         if (acc) model_pend = 1'b0;
         else if (inj) model_pend = 1'b1;
      end
      model_armed = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid_i = 1'b0; in_data_i = '0; push_grant_i = 1'b0; inject_i = 1'b0;
      model_reset();
      #2;
      check_count++; if (in_ready_o !== 1'b0) $display("[TB] FAIL reset_ready got %b expected 0", in_ready_o); else pass_count++;
      check_count++; if (push_valid_o !== 1'b0) $display("[TB] FAIL reset_valid got %b expected 0", push_valid_o); else pass_count++;
      check_count++; if (push_data_o !== 33'h0) $display("[TB] FAIL reset_data got %h expected 0", push_data_o); else pass_count++;
      check_count++; if (tx_count_o !== 32'h0) $display("[TB] FAIL reset_count got %0d expected 0", tx_count_o); else pass_count++;
      check_count++; if (inject_pending_o !== 1'b0) $display("[TB] FAIL reset_pending got %b expected 0", inject_pending_o); else pass_count++;
      #3 rst_n = 1'b1;
      @(posedge clk);
      model_armed = 1'b1;
      #1;
      check_count++; if (in_ready_o !== 1'b1) $display("[TB] FAIL post_reset_ready got %b expected 1", in_ready_o); else pass_count++;
      check_count++; if (push_valid_o !== 1'b0) $display("[TB] FAIL post_reset_valid got %b expected 0", push_valid_o); else pass_count++;
      check_count++; if (tx_count_o !== 32'h0) $display("[TB] FAIL post_reset_count got %0d expected 0", tx_count_o); else pass_count++;
   endtask

   task automatic test_even_parity();
      step(1'b1, 32'h3, 1'b1, 1'b0);
      check_count++; if (push_data_o !== 33'h0_00000003 || push_valid_o !== 1'b1) $display("[TB] FAIL even_word0 got %b/%h expected 1/%h", push_valid_o, push_data_o, 33'h0_00000003); else pass_count++;
      step(1'b1, 32'h7, 1'b1, 1'b0);
      check_count++; if (push_data_o !== 33'h1_00000007 || push_valid_o !== 1'b1) $display("[TB] FAIL even_word1 got %b/%h expected 1/%h", push_valid_o, push_data_o, 33'h1_00000007); else pass_count++;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check_count++; if (push_valid_o !== 1'b0) $display("[TB] FAIL even_drain_valid got %b expected 0", push_valid_o); else pass_count++;
      check_count++; if (tx_count_o !== 32'd2) $display("[TB] FAIL even_count got %0d expected 2", tx_count_o); else pass_count++;
   endtask

   task automatic test_odd_parity();
      step(1'b1, 32'h0, 1'b1, 1'b0);
      check_count++; if (odd_data !== 33'h1_00000000 || odd_valid !== 1'b1) $display("[TB] FAIL odd_zero got %b/%h expected 1/%h", odd_valid, odd_data, 33'h1_00000000); else pass_count++;
      check_count++; if (push_data_o !== 33'h0_00000000) $display("[TB] FAIL even_zero got %h expected %h", push_data_o, 33'h0_00000000); else pass_count++;
      step(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [31:0] start_cnt;
      start_cnt = model_cnt;
      step(1'b1, 32'h3, 1'b0, 1'b0);
      step(1'b1, 32'h6, 1'b0, 1'b0);
      check_count++; if (in_ready_o !== 1'b0) $display("[TB] FAIL bp_full_ready got %b expected 0", in_ready_o); else pass_count++;
      step(1'b1, 32'h9, 1'b0, 1'b0);
      check_count++; if (push_data_o !== 33'h0_00000003 || push_valid_o !== 1'b1) $display("[TB] FAIL bp_hold got %b/%h expected 1/%h", push_valid_o, push_data_o, 33'h0_00000003); else pass_count++;
      step(1'b1, 32'h9, 1'b1, 1'b0);
      check_count++; if (push_data_o !== 33'h0_00000006) $display("[TB] FAIL bp_order1 got %h expected %h", push_data_o, 33'h0_00000006); else pass_count++;
      step(1'b1, 32'h9, 1'b1, 1'b0);
      check_count++; if (push_data_o !== 33'h0_00000009) $display("[TB] FAIL bp_order2 got %h expected %h", push_data_o, 33'h0_00000009); else pass_count++;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check_count++; if (push_valid_o !== 1'b0) $display("[TB] FAIL bp_drain_valid got %b expected 0", push_valid_o); else pass_count++;
      check_count++; if (tx_count_o !== start_cnt + 32'd3) $display("[TB] FAIL bp_count got %0d expected %0d", tx_count_o, start_cnt + 32'd3); else pass_count++;
   endtask

   task automatic test_inject();
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_count++; if (inject_pending_o !== INJ) $display("[TB] FAIL inj_armed got %b expected %b", inject_pending_o, INJ); else pass_count++;
      step(1'b1, 32'h3, 1'b1, 1'b0);
      check_count++; if (push_data_o !== {INJ, 32'h3}) $display("[TB] FAIL inj_word got %h expected %h", push_data_o, {INJ, 32'h3}); else pass_count++;
      check_count++; if (inject_pending_o !== 1'b0) $display("[TB] FAIL inj_cleared got %b expected 0", inject_pending_o); else pass_count++;
      step(1'b1, 32'h6, 1'b1, 1'b0);
      check_count++; if (push_data_o !== 33'h0_00000006) $display("[TB] FAIL inj_next_clean got %h expected %h", push_data_o, 33'h0_00000006); else pass_count++;
      step(1'b1, 32'h5, 1'b1, 1'b1);
      check_count++; if (push_data_o !== {INJ, 32'h5}) $display("[TB] FAIL inj_same_edge got %h expected %h", push_data_o, {INJ, 32'h5}); else pass_count++;
      check_count++; if (inject_pending_o !== 1'b0) $display("[TB] FAIL inj_same_edge_pend got %b expected 0", inject_pending_o); else pass_count++;
      step(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      bit v, g, inj;
      logic [DW-1:0] d;
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         g   = ($urandom_range(0, 9) < 6);
         inj = ($urandom_range(0, 19) == 0);
         d   = $urandom;
         step(v, d, g, inj);
         check_count++; if (in_ready_o !== (model_q.size() < 2)) $display("[TB] FAIL rnd_ready cycle %0d got %b expected %b", i, in_ready_o, model_q.size() < 2); else pass_count++;
         check_count++; if (push_valid_o !== (model_q.size() > 0)) $display("[TB] FAIL rnd_valid cycle %0d got %b expected %b", i, push_valid_o, model_q.size() > 0); else pass_count++;
         if (model_q.size() > 0) begin
            check_count++; if (push_data_o !== model_q[0]) $display("[TB] FAIL rnd_data cycle %0d got %h expected %h", i, push_data_o, model_q[0]); else pass_count++;
         end
         check_count++; if (tx_count_o !== model_cnt) $display("[TB] FAIL rnd_count cycle %0d got %0d expected %0d", i, tx_count_o, model_cnt); else pass_count++;
         check_count++; if (inject_pending_o !== model_pend) $display("[TB] FAIL rnd_pending cycle %0d got %b expected %b", i, inject_pending_o, model_pend); else pass_count++;
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      check_count++; if (in_ready_o !== 1'b0 || push_valid_o !== 1'b1) $display("[TB] FAIL ar_two got %b/%b expected 0/1", in_ready_o, push_valid_o); else pass_count++;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_count++; if (push_valid_o !== 1'b0) $display("[TB] FAIL ar_valid got %b expected 0", push_valid_o); else pass_count++;
      check_count++; if (in_ready_o !== 1'b0) $display("[TB] FAIL ar_ready got %b expected 0", in_ready_o); else pass_count++;
      check_count++; if (tx_count_o !== 32'h0) $display("[TB] FAIL ar_count got %0d expected 0", tx_count_o); else pass_count++;
      check_count++; if (push_data_o !== 33'h0) $display("[TB] FAIL ar_data got %h expected 0", push_data_o); else pass_count++;
      #1 rst_n = 1'b1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check_count++; if (in_ready_o !== 1'b1 || push_valid_o !== 1'b0) $display("[TB] FAIL ar_after1 got %b/%b expected 1/0", in_ready_o, push_valid_o); else pass_count++;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check_count++; if (push_valid_o !== 1'b0 || tx_count_o !== 32'h0) $display("[TB] FAIL ar_no_reemit got %b/%0d expected 0/0", push_valid_o, tx_count_o); else pass_count++;
   endtask

   // run every scenario in order, then report
   initial begin
      test_reset();
      test_even_parity();
      test_odd_parity();
      test_backpressure();
      test_inject();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
